// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned), result = {remainder, quotient}.
// Optional `DIV_EARLY_OUT_EN` adds a two-edge shortcut when |dividend| < |divisor|.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o
);

    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int WORK_W = 2 * DATA_W + 1;

`ifdef DIV_EARLY_OUT_EN
    typedef enum logic [2:0] {S_FREE, S_DIVZERO, S_ON, S_EARLY, S_END} state_t;
`else
    typedef enum logic [2:0] {S_FREE, S_DIVZERO, S_ON, S_END} state_t;
`endif

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_W-1:0]     divisor_q;
    logic [WORK_W-1:0]     work_q;
    logic                  neg_quot_q, neg_rem_q;
    logic [2*DATA_W-1:0]   result_q;
    logic                  ready_q;

    logic                  op1_neg, op2_neg;
    logic [DATA_W-1:0]     op1_mag, op2_mag;
    logic [WORK_W-1:0]     shifted, work_step;
    logic [DATA_W+1:0]     trial;
    logic [DATA_W-1:0]     quot_fix, rem_fix;
    logic                  cnt_done, go;
    logic                  load, step, ready_d;
    logic [2*DATA_W-1:0]   result_d;

    // Magnitudes; negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    assign op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    assign op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    assign op1_mag = op1_neg ? -opdata1_i : opdata1_i;
    assign op2_mag = op2_neg ? -opdata2_i : opdata2_i;

    assign go       = start_i & ~annul_i;
    assign cnt_done = (cnt_q == CNT_W'(DATA_W));

    // One restoring step: the shifted-in quotient bit is 1 when the trial subtraction does not borrow.
    assign shifted   = {work_q[WORK_W-2:0], 1'b0};
    assign trial     = {1'b0, shifted[WORK_W-1:DATA_W]} - {2'b00, divisor_q};
    assign work_step = trial[DATA_W+1] ? shifted
                                       : {trial[DATA_W:0], shifted[DATA_W-1:1], 1'b1};

    assign quot_fix = neg_quot_q ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
    assign rem_fix  = neg_rem_q  ? -work_q[2*DATA_W-1:DATA_W] : work_q[2*DATA_W-1:DATA_W];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FREE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d = state_q;
        unique case (state_q)
            S_FREE: begin
                if (go) begin
                    if (opdata2_i == '0) begin
                        state_d = S_DIVZERO;
                    end else begin
`ifdef DIV_EARLY_OUT_EN
                        state_d = (op1_mag < op2_mag) ? S_EARLY : S_ON;
`else
                        state_d = S_ON;
`endif
                    end
                end
            end
            S_DIVZERO: state_d = S_END;
            S_ON: begin
                if (annul_i) begin
                    state_d = S_FREE;
                end else if (cnt_done) begin
                    state_d = S_END;
                end
            end
`ifdef DIV_EARLY_OUT_EN
            S_EARLY: state_d = annul_i ? S_FREE : S_END;
`endif
            S_END: begin
                if (!start_i) begin
                    state_d = S_FREE;
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    // Output / datapath control
    always_comb begin
        load     = 1'b0;
        step     = 1'b0;
        ready_d  = 1'b0;
        result_d = '0;
        unique case (state_q)
            S_FREE: load = go & (opdata2_i != '0);
            S_ON: begin
                if (!annul_i) begin
                    if (cnt_done) begin
                        result_d = {rem_fix, quot_fix};
                        ready_d  = 1'b1;
                    end else begin
                        step = 1'b1;
                    end
                end
            end
`ifdef DIV_EARLY_OUT_EN
            // The latched dividend magnitude is the whole remainder; neg_rem restores its sign.
            S_EARLY: begin
                if (!annul_i) begin
                    result_d = {(neg_rem_q ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0]),
                                {DATA_W{1'b0}}};
                    ready_d  = 1'b1;
                end
            end
`endif
            S_END: begin
                if (start_i) begin
                    result_d = result_q;
                    ready_d  = 1'b1;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the async reset clears every datapath register too, so a mid-division reset leaves nothing stale.
        if (rst) begin
            cnt_q      <= '0;
            divisor_q  <= '0;
            work_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            if (load) begin
                cnt_q      <= '0;
                divisor_q  <= op2_mag;
                work_q     <= {{(DATA_W+1){1'b0}}, op1_mag};
                neg_quot_q <= op1_neg ^ op2_neg;
                neg_rem_q  <= op1_neg;
            end else if (step) begin
                cnt_q  <= cnt_q + CNT_W'(1);
                work_q <= work_step;
            end
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: vector table plus annul/reset corner sequences.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1, op2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        string       name;
        logic        sd;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
        int          lat;
    } vec_t;

    // Edges from the first start-sampling edge up to and including the one that raises ready.
`ifdef DIV_EARLY_OUT_EN
    localparam int EL = 2;
`else
    localparam int EL = 34;
`endif

    vec_t vecs[12];

    div_unit #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp_v);
        end
    endtask

    // Waits for ready with a bound; returns the number of edges taken (100 = timed out).
    task automatic wait_ready(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (ready) break;
            if (lat == 1) begin
                op1 = $urandom;
                op2 = $urandom;
            end
        end
    endtask

    task automatic run_div(input vec_t v);
        int lat;
        signed_div = v.sd;
        op1        = v.a;
        op2        = v.b;
        start      = 1'b1;
        wait_ready(lat);
        check({v.name, " latency"}, 64'(lat), 64'(v.lat));
        check({v.name, " result"}, result, v.res);
        @(posedge clk); #1;
        check({v.name, " hold result"}, result, v.res);
        check({v.name, " hold ready"}, 64'(ready), 64'd1);
        start = 1'b0;
        @(posedge clk); #1;
        check({v.name, " release ready"}, 64'(ready), 64'd0);
        check({v.name, " release result"}, result, 64'd0);
        op1 = '0;
        op2 = '0;
    endtask

    initial begin
        int   lat;
        int   bad;
        vec_t v;

        vecs[0]  = '{"u 100/7",        1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 34};
        vecs[1]  = '{"s -7/2",         1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 34};
        vecs[2]  = '{"u fff9/2",       1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 34};
        vecs[3]  = '{"u 12345/0",      1'b0, 32'd12345,      32'd0,          64'h0,                 3};
        vecs[4]  = '{"s min/-1",       1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 34};
        vecs[5]  = '{"u 3/10",         1'b0, 32'd3,          32'd10,         64'h00000003_00000000, EL};
        vecs[6]  = '{"s -3/10",        1'b1, 32'hFFFFFFFD,   32'd10,         64'hFFFFFFFD_00000000, EL};
        vecs[7]  = '{"u max/1",        1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 34};
        vecs[8]  = '{"s 7/-2",         1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 34};
        vecs[9]  = '{"u 0/5",          1'b0, 32'd0,          32'd5,          64'h0,                 EL};
        vecs[10] = '{"u min/min",      1'b0, 32'h80000000,   32'h80000000,   64'h00000000_00000001, 34};
        vecs[11] = '{"s 0/0",          1'b1, 32'd0,          32'd0,          64'h0,                 3};

        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
        #2;
        check("reset ready", 64'(ready), 64'd0);
        check("reset result", result, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("idle ready", 64'(ready), 64'd0);

        foreach (vecs[i]) run_div(vecs[i]);

        // Annul mid-division at cnt = 10, then stay idle for 40 cycles.
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (11) @(posedge clk); #1;
        annul = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        bad = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready || result != 64'd0) bad++;
        end
        check("annul idle", 64'(bad), 64'd0);
        v = '{"u 9/3 after annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34};
        run_div(v);

        // Annul is ignored once the result is held in END.
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        wait_ready(lat);
        check("end-annul latency", 64'(lat), 64'd34);
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        check("end-annul ready", 64'(ready), 64'd1);
        check("end-annul result", result, 64'h00000002_0000000E);

        // Asynchronous reset while a result is held clears it without a clock edge.
        #2 rst = 1'b1;
        #1;
        check("async rst in end", {result[62:0], ready}, 64'd0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset between edges at cnt = 20.
        signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1;
        repeat (21) @(posedge clk); #1;
        #3 rst = 1'b1;
        #1;
        check("async rst mid ready", 64'(ready), 64'd0);
        check("async rst mid result", result, 64'd0);
        #1 rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        v = '{"u 50/5 after rst", 1'b0, 32'd50, 32'd5, 64'h00000000_0000000A, 34};
        run_div(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
